// File: rtl/axi_decerr_responder.sv
// Default-slave AXI4 responder: completes every write and read burst with DECERR
// and keeps a saturating failure count plus the last failing address.
module axi_decerr_responder #(
  parameter int unsigned          IdWidth   = 5,
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          DataWidth = 64,
  parameter logic [DataWidth-1:0] RespData  = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [IdWidth-1:0]     aw_id_i,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  input  logic                   w_last_i,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  output logic [IdWidth-1:0]     b_id_o,
  output logic [1:0]             b_resp_o,
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  input  logic [IdWidth-1:0]     ar_id_i,
  input  logic [AddrWidth-1:0]   ar_addr_i,
  input  logic [7:0]             ar_len_i,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [IdWidth-1:0]     r_id_o,
  output logic [DataWidth-1:0]   r_data_o,
  output logic [1:0]             r_resp_o,
  output logic                   r_last_o,
  output logic [31:0]            err_cnt_o,
  output logic [AddrWidth-1:0]   err_addr_o
);

  typedef enum logic [1:0] {W_IDLE = 2'b00, W_DATA = 2'b01, W_RESP = 2'b10} w_state_e;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  localparam logic [1:0] RespDecErr = 2'b11;

  w_state_e              w_state_q, w_state_d;
  r_state_e              r_state_q, r_state_d;
  logic                  init_q, init_d;
  logic [IdWidth-1:0]    b_id_q, b_id_d;
  logic [IdWidth-1:0]    r_id_q, r_id_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic [31:0]           err_cnt_q, err_cnt_d;
  logic [AddrWidth-1:0]  err_addr_q, err_addr_d;
  logic                  aw_hs_s, ar_hs_s, b_done_s, r_done_s;
  logic [1:0]            done_inc_s;
  logic [32:0]           cnt_sum_s;
  logic                  unused_wdata_s;

  // Write payload is discarded by design.
  assign unused_wdata_s = ^{w_data_i, w_strb_i};

  // State and bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      init_q     <= 1'b0;
      b_id_q     <= {IdWidth{1'b0}};
      r_id_q     <= {IdWidth{1'b0}};
      r_cnt_q    <= 8'd0;
      err_cnt_q  <= 32'd0;
      err_addr_q <= {AddrWidth{1'b0}};
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      init_q     <= init_d;
      b_id_q     <= b_id_d;
      r_id_q     <= r_id_d;
      r_cnt_q    <= r_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Write channel: accept AW, swallow W beats until last, then return B.
  always_comb begin
    w_state_d  = w_state_q;
    b_id_d     = b_id_q;
    aw_hs_s    = 1'b0;
    b_done_s   = 1'b0;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    b_id_o     = {IdWidth{1'b0}};
    b_resp_o   = 2'b00;
    case (w_state_q)
      W_IDLE: begin
        aw_ready_o = init_q;
        if (aw_valid_i && init_q) begin
          aw_hs_s   = 1'b1;
          b_id_d    = aw_id_i;
          w_state_d = W_DATA;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        w_ready_o = 1'b1;
        if (w_valid_i && w_last_i) begin
          w_state_d = W_RESP;
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        b_valid_o = 1'b1;
        b_id_o    = b_id_q;
        b_resp_o  = RespDecErr;
        if (b_ready_i) begin
          b_done_s  = 1'b1;
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
  end

  // Read channel: beat counter ends the burst when it reads zero before decrement,
  // so a length of 255 yields 256 beats without wrapping.
  always_comb begin
    r_state_d  = r_state_q;
    r_id_d     = r_id_q;
    r_cnt_d    = r_cnt_q;
    ar_hs_s    = 1'b0;
    r_done_s   = 1'b0;
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    r_id_o     = {IdWidth{1'b0}};
    r_data_o   = {DataWidth{1'b0}};
    r_resp_o   = 2'b00;
    r_last_o   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_ready_o = init_q;
        if (ar_valid_i && init_q) begin
          ar_hs_s   = 1'b1;
          r_id_d    = ar_id_i;
          r_cnt_d   = ar_len_i;
          r_state_d = R_DATA;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        r_valid_o = 1'b1;
        r_id_o    = r_id_q;
        r_data_o  = RespData;
        r_resp_o  = RespDecErr;
        r_last_o  = (r_cnt_q == 8'd0);
        if (r_ready_i && (r_cnt_q == 8'd0)) begin
          r_done_s  = 1'b1;
          r_state_d = R_IDLE;
        end else if (r_ready_i) begin
          r_cnt_d   = r_cnt_q - 8'd1;
          r_state_d = R_DATA;
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase
  end

  // Statistics: AR address wins on a tie; counter saturates instead of wrapping.
  always_comb begin
    init_d     = 1'b1;
    done_inc_s = {1'b0, b_done_s} + {1'b0, r_done_s};
    cnt_sum_s  = {1'b0, err_cnt_q} + {31'd0, done_inc_s};
    if (cnt_sum_s[32]) begin
      err_cnt_d = 32'hFFFF_FFFF;
    end else begin
      err_cnt_d = cnt_sum_s[31:0];
    end
    if (ar_hs_s) begin
      err_addr_d = ar_addr_i;
    end else if (aw_hs_s) begin
      err_addr_d = aw_addr_i;
    end else begin
      err_addr_d = err_addr_q;
    end
  end

  assign err_cnt_o  = err_cnt_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_axi_decerr_responder.sv
// Directed self-checking bench for axi_decerr_responder.
module tb_axi_decerr_responder;

  localparam logic [63:0] RESP_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        aw_valid_i = 1'b0, aw_ready_o;
  logic [4:0]  aw_id_i = 5'd0;
  logic [63:0] aw_addr_i = 64'd0;
  logic        w_valid_i = 1'b0, w_ready_o, w_last_i = 1'b0;
  logic [63:0] w_data_i = 64'd0;
  logic [7:0]  w_strb_i = 8'd0;
  logic        b_valid_o, b_ready_i = 1'b0;
  logic [4:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        ar_valid_i = 1'b0, ar_ready_o;
  logic [4:0]  ar_id_i = 5'd0;
  logic [63:0] ar_addr_i = 64'd0;
  logic [7:0]  ar_len_i = 8'd0;
  logic        r_valid_o, r_ready_i = 1'b0;
  logic [4:0]  r_id_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic [31:0] err_cnt_o;
  logic [63:0] err_addr_o;

  int check_count = 0;
  int error_count = 0;

  axi_decerr_responder dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
    .w_data_i(w_data_i), .w_strb_i(w_strb_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i),
    .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .err_cnt_o(err_cnt_o), .err_addr_o(err_addr_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    check_count++;
    if (obs !== exp_v) begin
      error_count++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] id, input logic [63:0] addr);
    aw_valid_i = 1'b1; aw_id_i = id; aw_addr_i = addr;
    tick();
    aw_valid_i = 1'b0; w_valid_i = 1'b1; w_last_i = 1'b1;
    tick();
    w_valid_i = 1'b0; w_last_i = 1'b0; b_ready_i = 1'b1;
    tick();
    b_ready_i = 1'b0;
  endtask

  task automatic start_read(input logic [4:0] id, input logic [63:0] addr, input logic [7:0] len);
    ar_valid_i = 1'b1; ar_id_i = id; ar_addr_i = addr; ar_len_i = len;
    tick();
    ar_valid_i = 1'b0;
  endtask

  initial begin
    int beats;
    int last_beat;
    bit done;

    // Reset state
    tick();
    tick();
    check_val("rst_aw_ready", {63'd0, aw_ready_o}, 64'd0);
    check_val("rst_ar_ready", {63'd0, ar_ready_o}, 64'd0);
    check_val("rst_r_data", r_data_o, 64'd0);
    check_val("rst_err_cnt", {32'd0, err_cnt_o}, 64'd0);
    check_val("rst_err_addr", err_addr_o, 64'd0);
    rst_ni = 1'b1;
    #1;
    check_val("aw_ready_at_release", {63'd0, aw_ready_o}, 64'd0);
    tick();
    check_val("aw_ready_after_init", {63'd0, aw_ready_o}, 64'd1);
    check_val("ar_ready_after_init", {63'd0, ar_ready_o}, 64'd1);

    // Single write with early W stalled
    aw_valid_i = 1'b1; aw_id_i = 5'h13; aw_addr_i = 64'h5000_0000;
    w_valid_i = 1'b1; w_last_i = 1'b1;
    check_val("w_ready_idle", {63'd0, w_ready_o}, 64'd0);
    tick();
    aw_valid_i = 1'b0;
    check_val("w_ready_data", {63'd0, w_ready_o}, 64'd1);
    check_val("aw_ready_busy", {63'd0, aw_ready_o}, 64'd0);
    tick();
    w_valid_i = 1'b0; w_last_i = 1'b0;
    check_val("b_valid", {63'd0, b_valid_o}, 64'd1);
    check_val("b_id", {59'd0, b_id_o}, 64'h13);
    check_val("b_resp", {62'd0, b_resp_o}, 64'd3);
    check_val("wr_err_addr", err_addr_o, 64'h5000_0000);
    tick();
    check_val("b_hold_valid", {63'd0, b_valid_o}, 64'd1);
    check_val("b_hold_id", {59'd0, b_id_o}, 64'h13);
    check_val("cnt_before_b", {32'd0, err_cnt_o}, 64'd0);
    b_ready_i = 1'b1;
    tick();
    b_ready_i = 1'b0;
    check_val("b_valid_done", {63'd0, b_valid_o}, 64'd0);
    check_val("cnt_after_wr", {32'd0, err_cnt_o}, 64'd1);

    // Four-beat read, r_ready held high
    r_ready_i = 1'b1;
    start_read(5'h07, 64'h6000_0000, 8'd3);
    for (int b = 0; b < 4; b++) begin
      check_val("rd4_valid", {63'd0, r_valid_o}, 64'd1);
      check_val("rd4_data", r_data_o, RESP_DATA);
      check_val("rd4_resp", {62'd0, r_resp_o}, 64'd3);
      check_val("rd4_id", {59'd0, r_id_o}, 64'h07);
      check_val("rd4_last", {63'd0, r_last_o}, (b == 3) ? 64'd1 : 64'd0);
      tick();
    end
    r_ready_i = 1'b0;
    check_val("rd4_valid_end", {63'd0, r_valid_o}, 64'd0);
    check_val("rd4_cnt", {32'd0, err_cnt_o}, 64'd2);
    check_val("rd4_err_addr", err_addr_o, 64'h6000_0000);

    // Single-beat read under backpressure
    start_read(5'h0A, 64'h7000_0008, 8'd0);
    for (int c = 0; c < 5; c++) begin
      check_val("bp_valid", {63'd0, r_valid_o}, 64'd1);
      check_val("bp_last", {63'd0, r_last_o}, 64'd1);
      check_val("bp_id", {59'd0, r_id_o}, 64'h0A);
      check_val("bp_data", r_data_o, RESP_DATA);
      tick();
    end
    r_ready_i = 1'b1;
    tick();
    r_ready_i = 1'b0;
    check_val("bp_valid_end", {63'd0, r_valid_o}, 64'd0);
    check_val("bp_cnt", {32'd0, err_cnt_o}, 64'd3);

    // Simultaneous AW/AR, coincident B and last R
    aw_valid_i = 1'b1; aw_id_i = 5'h01; aw_addr_i = 64'h8000_0000;
    ar_valid_i = 1'b1; ar_id_i = 5'h02; ar_addr_i = 64'h9000_0000; ar_len_i = 8'd0;
    tick();
    aw_valid_i = 1'b0; ar_valid_i = 1'b0;
    check_val("sim_err_addr", err_addr_o, 64'h9000_0000);
    w_valid_i = 1'b1; w_last_i = 1'b1;
    tick();
    w_valid_i = 1'b0; w_last_i = 1'b0;
    check_val("sim_b_id", {59'd0, b_id_o}, 64'h01);
    check_val("sim_r_id", {59'd0, r_id_o}, 64'h02);
    b_ready_i = 1'b1; r_ready_i = 1'b1;
    tick();
    b_ready_i = 1'b0; r_ready_i = 1'b0;
    check_val("sim_cnt_plus2", {32'd0, err_cnt_o}, 64'd5);

    // Saturation near the top of the counter
    force dut.err_cnt_q = 32'hFFFF_FFFE;
    tick();
    release dut.err_cnt_q;
    #1;
    check_val("sat_preload", {32'd0, err_cnt_o}, 64'hFFFF_FFFE);
    do_write(5'h04, 64'hB000_0000);
    check_val("sat_reach", {32'd0, err_cnt_o}, 64'hFFFF_FFFF);
    r_ready_i = 1'b1;
    start_read(5'h05, 64'hB000_0100, 8'd0);
    tick();
    r_ready_i = 1'b0;
    check_val("sat_hold", {32'd0, err_cnt_o}, 64'hFFFF_FFFF);

    // 256-beat read
    r_ready_i = 1'b1;
    start_read(5'h06, 64'hC000_0000, 8'd255);
    beats = 0; last_beat = 0; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (r_valid_o) begin
        beats++;
        if (r_last_o) begin
          last_beat = beats;
          done = 1'b1;
        end
      end
      tick();
    end
    r_ready_i = 1'b0;
    check_val("len255_done", {63'd0, done}, 64'd1);
    check_val("len255_beats", beats, 64'd256);
    check_val("len255_last_pos", last_beat, 64'd256);
    check_val("len255_idle", {63'd0, r_valid_o}, 64'd0);

    // Reset in the middle of an 8-beat read
    r_ready_i = 1'b1;
    start_read(5'h08, 64'hD000_0000, 8'd7);
    tick();
    tick();
    tick();
    check_val("mid_valid_pre", {63'd0, r_valid_o}, 64'd1);
    rst_ni = 1'b0;
    #1;
    check_val("mid_rst_valid", {63'd0, r_valid_o}, 64'd0);
    check_val("mid_rst_cnt", {32'd0, err_cnt_o}, 64'd0);
    check_val("mid_rst_addr", err_addr_o, 64'd0);
    r_ready_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    check_val("post_rst_ar_ready", {63'd0, ar_ready_o}, 64'd1);
    check_val("post_rst_r_valid", {63'd0, r_valid_o}, 64'd0);
    r_ready_i = 1'b1;
    start_read(5'h03, 64'hA000_0000, 8'd1);
    check_val("post_b0_id", {59'd0, r_id_o}, 64'h03);
    check_val("post_b0_last", {63'd0, r_last_o}, 64'd0);
    tick();
    check_val("post_b1_last", {63'd0, r_last_o}, 64'd1);
    tick();
    r_ready_i = 1'b0;
    check_val("post_cnt", {32'd0, err_cnt_o}, 64'd1);
    check_val("post_err_addr", err_addr_o, 64'hA000_0000);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
